// File: rtl/mod11_seq_checker_if.sv
// Observation bus between a mod-11 counter (or its driver) and the sequence checker.
// The counter side drives the sample/load/count signals; the checker returns its status.
interface mod11_seq_checker_if #(
  parameter int ERR_CNT_W = 8
) ();
  logic                 sample_en;
  logic                 load_en;
  logic [3:0]           cnt_in;
  logic [3:0]           expected;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 wrap_pulse;
  logic [7:0]           wrap_count;

  modport master (
    output sample_en, load_en, cnt_in,
    input  expected, locked, err_pulse, err_count, wrap_pulse, wrap_count
  );

  modport slave (
    input  sample_en, load_en, cnt_in,
    output expected, locked, err_pulse, err_count, wrap_pulse, wrap_count
  );
endinterface

// File: rtl/mod11_seq_checker.sv
// Receive-side checker for a loadable mod-MOD counter stream: locks after LOCK_THRESH
// consistent samples, then flags/counts mismatches, out-of-range values and wraps.
module mod11_seq_checker #(
  parameter int MOD         = 11,
  parameter int LOCK_THRESH = 3,
  parameter int ERR_CNT_W   = 8
) (
  input logic            clk,
  input logic            rst,
  mod11_seq_checker_if.slave bus
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t               state, state_nxt;
  logic [3:0]           expected_q, expected_nxt;
  logic [3:0]           good, good_nxt;
  logic                 err_pulse_q, err_pulse_nxt;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_nxt;
  logic                 wrap_pulse_q, wrap_pulse_nxt;
  logic [7:0]           wrap_count_q, wrap_count_nxt;

  logic                 in_range;
  logic [3:0]           inc_v;
  logic [ERR_CNT_W-1:0] err_count_sat;
  logic                 reach_lock;

  // 5-bit compares keep MOD=16 and LOCK_THRESH=15 representable.
  assign in_range      = ({1'b0, bus.cnt_in} < 5'(MOD));
  assign inc_v         = (bus.cnt_in == 4'(MOD - 1)) ? 4'd0 : bus.cnt_in + 4'd1;
  assign err_count_sat = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;
  assign reach_lock    = (({1'b0, good} + 5'd1) == 5'(LOCK_THRESH));

  always_comb begin
    state_nxt      = state;
    expected_nxt   = expected_q;
    good_nxt       = good;
    err_pulse_nxt  = 1'b0;
    err_count_nxt  = err_count_q;
    wrap_pulse_nxt = 1'b0;
    wrap_count_nxt = wrap_count_q;

    if (bus.sample_en) begin
      unique case (state)
        SEARCH: begin
          if (in_range) begin
            expected_nxt = inc_v;
            good_nxt     = 4'd1;
            state_nxt    = (LOCK_THRESH == 1) ? LOCKED : VERIFY;
          end else begin
            err_pulse_nxt = 1'b1;
            err_count_nxt = err_count_sat;
          end
        end

        VERIFY: begin
          if (!in_range) begin
            err_pulse_nxt = 1'b1;
            err_count_nxt = err_count_sat;
            good_nxt      = 4'd0;
            state_nxt     = SEARCH;
          end else if (bus.cnt_in == expected_q || bus.load_en) begin
            expected_nxt = inc_v;
            good_nxt     = good + 4'd1;
            if (reach_lock) state_nxt = LOCKED;
          end else begin
            // Quiet reseed: before lock a mismatch just restarts the run.
            expected_nxt = inc_v;
            good_nxt     = 4'd1;
          end
        end

        LOCKED: begin
          if (!in_range) begin
            err_pulse_nxt = 1'b1;
            err_count_nxt = err_count_sat;
            state_nxt     = SEARCH;
          end else if (bus.load_en) begin
            expected_nxt = inc_v;
          end else if (bus.cnt_in == expected_q) begin
            expected_nxt = inc_v;
            if (bus.cnt_in == 4'd0) begin
              wrap_pulse_nxt = 1'b1;
              wrap_count_nxt = wrap_count_q + 8'd1;
            end
          end else begin
            err_pulse_nxt = 1'b1;
            err_count_nxt = err_count_sat;
            expected_nxt  = inc_v;
            good_nxt      = 4'd1;
            state_nxt     = (LOCK_THRESH == 1) ? LOCKED : VERIFY;
          end
        end

        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= SEARCH;
      expected_q   <= '0;
      good         <= '0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      wrap_pulse_q <= 1'b0;
      wrap_count_q <= '0;
    end else begin
      state        <= state_nxt;
      expected_q   <= expected_nxt;
      good         <= good_nxt;
      err_pulse_q  <= err_pulse_nxt;
      err_count_q  <= err_count_nxt;
      wrap_pulse_q <= wrap_pulse_nxt;
      wrap_count_q <= wrap_count_nxt;
    end
  end

  assign bus.expected   = expected_q;
  assign bus.locked     = (state == LOCKED);
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_count  = err_count_q;
  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.wrap_count = wrap_count_q;

endmodule

// File: tb/tb_mod11_seq_checker.sv
// Scoreboard bench for mod11_seq_checker (MOD=11, LOCK_THRESH=3, ERR_CNT_W=2):
// the driver queues hand-computed outputs per edge, a monitor pops and compares after each edge.
module tb_mod11_seq_checker;

  logic clk;
  logic rst;

  mod11_seq_checker_if #(.ERR_CNT_W(2)) bus ();

  mod11_seq_checker #(
    .MOD         (11),
    .LOCK_THRESH (3),
    .ERR_CNT_W   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] e;
    logic       l;
    logic       ep;
    logic [1:0] ec;
    logic       wp;
    logic [7:0] wc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_idx  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL vec %0d %s: got %0d, expected %0d", vec_idx, name, act, req);
    end
  endtask

  // Monitor: outputs are registered, so compare 1 ns after each rising edge.
  always @(posedge clk) begin
    exp_t r;
    #1;
    if (q.size() > 0) begin
      r = q.pop_front();
      chk("expected",   int'(bus.expected),   int'(r.e));
      chk("locked",     int'(bus.locked),     int'(r.l));
      chk("err_pulse",  int'(bus.err_pulse),  int'(r.ep));
      chk("err_count",  int'(bus.err_count),  int'(r.ec));
      chk("wrap_pulse", int'(bus.wrap_pulse), int'(r.wp));
      chk("wrap_count", int'(bus.wrap_count), int'(r.wc));
      vec_idx++;
    end
  end

  // Drive one edge's inputs and queue the outputs required right after that edge.
  task automatic step(input int r, input int se, input int ld, input int v,
                      input int e, input int l, input int ep, input int ec,
                      input int wp, input int wc);
    exp_t x;
    @(negedge clk);
    rst           = 1'(r);
    bus.sample_en = 1'(se);
    bus.load_en   = 1'(ld);
    bus.cnt_in    = 4'(v);
    x.e  = 4'(e);
    x.l  = 1'(l);
    x.ep = 1'(ep);
    x.ec = 2'(ec);
    x.wp = 1'(wp);
    x.wc = 8'(wc);
    q.push_back(x);
  endtask

  initial begin
    int wc;
    int v;
    int e;
    int waited;
    rst           = 1'b0;
    bus.sample_en = 1'b0;
    bus.load_en   = 1'b0;
    bus.cnt_in    = 4'd0;

    //    rst se ld  v   exp lk ep ec wp wc
    step(0, 0, 0,  0,  0, 0, 0, 0, 0, 0);
    step(0, 1, 0,  5,  0, 0, 0, 0, 0, 0);   // reset overrides sample
    // acquire lock on 0,1,2,3
    step(1, 1, 0,  0,  1, 0, 0, 0, 0, 0);
    step(1, 1, 0,  1,  2, 0, 0, 0, 0, 0);
    step(1, 1, 0,  2,  3, 1, 0, 0, 0, 0);
    step(1, 1, 0,  3,  4, 1, 0, 0, 0, 0);
    step(1, 0, 0,  7,  4, 1, 0, 0, 0, 0);   // gap holds
    // wrap: load 9, then 10,0,1
    step(1, 1, 1,  9, 10, 1, 0, 0, 0, 0);
    step(1, 1, 0, 10,  0, 1, 0, 0, 0, 0);
    step(1, 1, 0,  0,  1, 1, 0, 0, 1, 1);
    step(1, 1, 0,  1,  2, 1, 0, 0, 0, 1);
    // locked mismatch at expected=5, relock on 8,9
    step(1, 1, 0,  2,  3, 1, 0, 0, 0, 1);
    step(1, 1, 0,  3,  4, 1, 0, 0, 0, 1);
    step(1, 1, 0,  4,  5, 1, 0, 0, 0, 1);
    step(1, 1, 0,  7,  8, 0, 1, 1, 0, 1);
    step(1, 0, 0,  8,  8, 0, 0, 1, 0, 1);
    step(1, 1, 0,  8,  9, 0, 0, 1, 0, 1);
    step(1, 1, 0,  9, 10, 1, 0, 1, 0, 1);
    // legal load while locked, then range error drops to SEARCH
    step(1, 1, 1,  4,  5, 1, 0, 1, 0, 1);
    step(1, 1, 1,  2,  3, 1, 0, 1, 0, 1);
    step(1, 1, 0, 12,  3, 0, 1, 2, 0, 1);
    step(1, 0, 0,  3,  3, 0, 0, 2, 0, 1);
    // VERIFY: range+load is an error; reseed is quiet; load counts as consistent
    step(1, 1, 0,  6,  7, 0, 0, 2, 0, 1);
    step(1, 1, 1, 13,  7, 0, 1, 3, 0, 1);
    step(1, 1, 0,  3,  4, 0, 0, 3, 0, 1);
    step(1, 1, 0,  8,  9, 0, 0, 3, 0, 1);
    step(1, 1, 1,  1,  2, 0, 0, 3, 0, 1);
    step(1, 1, 0,  2,  3, 1, 0, 3, 0, 1);
    step(1, 1, 1, 14,  3, 0, 1, 3, 0, 1);   // locked range+load, count saturated
    // mid-lock reset with concurrent sample, then first edge out of reset samples
    step(1, 1, 0,  5,  6, 0, 0, 3, 0, 1);
    step(1, 1, 0,  6,  7, 0, 0, 3, 0, 1);
    step(1, 1, 0,  7,  8, 1, 0, 3, 0, 1);
    step(0, 1, 0,  4,  0, 0, 0, 0, 0, 0);
    step(1, 1, 0,  4,  5, 0, 0, 0, 0, 0);
    // saturation: five range errors from reset
    step(0, 0, 0,  0,  0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 15,  0, 0, 1, 1, 0, 0);
    step(1, 1, 0, 15,  0, 0, 1, 2, 0, 0);
    step(1, 1, 0, 15,  0, 0, 1, 3, 0, 0);
    step(1, 1, 0, 15,  0, 0, 1, 3, 0, 0);
    step(1, 1, 0, 15,  0, 0, 1, 3, 0, 0);
    // wrap_count rolls 255 -> 0 after 256 locked laps
    step(0, 0, 0,  0,  0, 0, 0, 0, 0, 0);
    step(1, 1, 0,  0,  1, 0, 0, 0, 0, 0);
    step(1, 1, 0,  1,  2, 0, 0, 0, 0, 0);
    step(1, 1, 0,  2,  3, 1, 0, 0, 0, 0);
    wc = 0;
    for (int k = 0; k < 256; k++) begin
      for (int j = 0; j < 11; j++) begin
        v = (3 + j) % 11;
        e = (v == 10) ? 0 : v + 1;
        if (v == 0) wc = (wc + 1) % 256;
        step(1, 1, 0, v, e, 1, 0, 0, (v == 0) ? 1 : 0, wc);
      end
    end
    step(1, 0, 0,  0,  3, 1, 0, 0, 0, 0);

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    #2;
    chk("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
